girl_sprite_fetch: RTL and testbench
====================================

// Module: girl_sprite_fetch
// PURPOSE
//  Upstream feeder of the girl sprite palette LUT (4-bit index -> 12-bit RGB).
//  Per VGA pixel: tests whether the pixel lies inside the girl sprite box and
//  forms the sprite-ROM address (animation frame, row, mirrored column).
//  Returns the ROM's 4-bit palette index, with a hit flag, 3 cycles later.
//  Owns the walk-animation frame sequencer, latched once per video frame.
// PARAMETERS
//  SPRITE_W    32  sprite width, pixels
//  SPRITE_H    32  sprite height, pixels
//  FRAMES      4   walk frames stored back-to-back in ROM (frame-major)
//  FRAME_HOLD  6   frame_start pulses per animation frame while moving
//  ADDR_W      $clog2(FRAMES*SPRITE_W*SPRITE_H)  ROM address width
// PORTS
//  clk          in   1       pixel clock
//  reset_n      in   1       asynchronous, active-low reset
//  frame_start  in   1       1-cycle pulse at start of vertical blank
//  moving       in   1       character walking (from player controller)
//  face_left    in   1       1 = mirror sprite horizontally
//  sprite_x     in   10      sprite top-left x, screen pixels
//  sprite_y     in   10      sprite top-left y, screen pixels
//  draw_x       in   10      current pixel x
//  draw_y       in   10      current pixel y
//  pix_en       in   1       pixel strobe; draw_x/draw_y valid this cycle
//  rom_addr     out  ADDR_W  registered address to synchronous sprite ROM
//  rom_data     in   4       ROM index, valid 1 cycle after rom_addr
//  pal_index    out  4       palette index to palette LUT
//  pal_hit      out  1       1 = inside sprite AND index != 0 (0 = colour key)
//  pal_valid    out  1       pal_index/pal_hit valid this cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): rom_addr=0, pal_index=0, pal_hit=0,
//   pal_valid=0, frame=0, hold count=0, latched face=0. All pipe valids clear.
//  Animation (updates only on frame_start):
//   - moving=0: frame<=0, hold<=0.
//   - moving=1: hold==FRAME_HOLD-1 -> hold<=0, frame<=(frame+1)%FRAMES;
//     otherwise hold<=hold+1.
//   - face_left is sampled into face_q on the same pulse.
//   - frame and face_q are constant for a whole frame (no mid-frame tearing).
//  Pipeline (pix_en at edge N):
//   - S1, edge N+1:
//     - dx=draw_x-sprite_x, dy=draw_y-sprite_y, 11-bit signed.
//     - in1 = dx>=0 && dx<SPRITE_W && dy>=0 && dy<SPRITE_H.
//     - col = face_q ? SPRITE_W-1-dx : dx.
//     - rom_addr <= frame*SPRITE_W*SPRITE_H + dy*SPRITE_W + col
//       when in1, else 0.
//     - v1<=1.
//   - S2, edge N+2: ROM presents rom_data; in2<=in1, v2<=v1.
//   - S3, edge N+3:
//     - pal_index <= in2 ? rom_data : 0.
//     - pal_hit <= in2 && rom_data!=0.
//     - pal_valid <= v2.
//   - Latency: exactly 3 cycles, fully pipelined; one pixel per cycle.
//   - pix_en=0 inserts a bubble: valid bit 0, data regs hold.
//  Boundaries:
//   - Sprite off-screen or partly off (sprite_x>=630 etc.): edge pixels
//     miss and never alias; the 11-bit compare prevents wrap.
//   - dx==SPRITE_W-1 with face_q=1 -> col=0.
//   - frame_start coincident with pix_en: pipeline unaffected. The new
//     frame/face apply from the next pix_en.
//   - reset mid-line: pipeline flushed; first pal_valid 3 cycles after
//     the first post-reset pix_en.
// STRUCTURE
//  sprite_pkg:
//   - SPRITE_W, SPRITE_H, FRAMES, FRAME_HOLD, COLOR_KEY_IDX=4'd0.
//   - typedef pix_coord_t (logic [9:0]).
//  Sub-module girl_anim_seq:
//   - frame/hold counters and face latch.
//   - Ports: clk, reset_n, frame_start, moving, face_left, frame, face_q.
//  Top: 3-stage address/hit pipeline plus output registers.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> all outputs 0 same cycle; no pal_valid
//    until 3 cycles after pix_en.
//  2 sprite=(100,50), frame 0, face 0, draw=(105,52) ->
//    rom_addr=69 at N+1; rom_data=3 -> pal_index=3, pal_hit=1 at N+3.
//  3 Same with face_left latched=1 -> rom_addr=90. draw=(132,52)
//    (dx=32) -> pal_hit=0, pal_index=0, pal_valid=1.
//  4 moving=1 for 6 frame_start pulses -> frame=1 (address +1024).
//    After 24 pulses -> frame 0. moving=0 at a pulse -> frame 0 immediately.
//  5 rom_data=0 inside box -> pal_hit=0. Continuous pix_en with a 1-cycle
//    gap -> pal_valid shows the same gap.
//  6 sprite_x=630, draw_x=5 -> miss (no wrap); face_left toggled mid-frame
//    -> address unchanged until next frame_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared geometry, animation constants and pixel types for the girl sprite fetch path.
package sprite_pkg;

  localparam int unsigned SPRITE_W   = 32;
  localparam int unsigned SPRITE_H   = 32;
  localparam int unsigned FRAMES     = 4;
  localparam int unsigned FRAME_HOLD = 6;

  localparam int unsigned ADDR_W  = $clog2(FRAMES * SPRITE_W * SPRITE_H);
  localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int unsigned COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned ROW_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [3:0] COLOR_KEY_IDX = 4'd0;

  typedef logic [9:0]        pix_coord_t;
  typedef logic signed [10:0] pix_delta_t;

endpackage

// File: rtl/girl_anim_seq.sv
// Walk-animation frame sequencer; frame and facing change only on frame_start.
module girl_anim_seq
  import sprite_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_frame_start,
  input  logic               i_moving,
  input  logic               i_face_left,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_face_q
);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

  logic [FRAME_W-1:0] r_frame;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_face;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame <= '0;
      r_hold  <= '0;
      r_face  <= 1'b0;
    end else if (i_frame_start) begin
      r_face <= i_face_left;
      if (!i_moving) begin
        r_frame <= '0;
        r_hold  <= '0;
      end else if (r_hold == HOLD_LAST) begin
        r_hold  <= '0;
        r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign o_frame  = r_frame;
  assign o_face_q = r_face;

endmodule

// File: rtl/girl_sprite_fetch.sv
// Sprite box test, ROM address generation and 3-cycle palette-index pipeline.
module girl_sprite_fetch
  import sprite_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_frame_start,
  input  logic              i_moving,
  input  logic              i_face_left,
  input  pix_coord_t        i_sprite_x,
  input  pix_coord_t        i_sprite_y,
  input  pix_coord_t        i_draw_x,
  input  pix_coord_t        i_draw_y,
  input  logic              i_pix_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [3:0]        i_rom_data,
  output logic [3:0]        o_pal_index,
  output logic              o_pal_hit,
  output logic              o_pal_valid
);

  localparam logic [9:0]       SPRITE_W_C = 10'(SPRITE_W);
  localparam logic [9:0]       SPRITE_H_C = 10'(SPRITE_H);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(SPRITE_W - 1);

  logic [FRAME_W-1:0] w_frame;
  logic               w_face;

  girl_anim_seq u_anim_seq (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_frame_start (i_frame_start),
    .i_moving      (i_moving),
    .i_face_left   (i_face_left),
    .o_frame       (w_frame),
    .o_face_q      (w_face)
  );

  pix_delta_t        w_dx;
  pix_delta_t        w_dy;
  logic              w_in;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_addr;

  // 11-bit signed deltas keep off-screen sprites from wrapping into the box.
  assign w_dx = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_sprite_x});
  assign w_dy = $signed({1'b0, i_draw_y}) - $signed({1'b0, i_sprite_y});

  assign w_in = !w_dx[10] && (w_dx[9:0] < SPRITE_W_C) &&
                !w_dy[10] && (w_dy[9:0] < SPRITE_H_C);

  assign w_col  = w_face ? (COL_LAST - w_dx[COL_W-1:0]) : w_dx[COL_W-1:0];
  assign w_addr = ADDR_W'(w_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
                + ADDR_W'(w_dy[ROW_W-1:0]) * ADDR_W'(SPRITE_W)
                + ADDR_W'(w_col);

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_in1;
  logic              r_v1;
  logic              r_in2;
  logic              r_v2;
  logic [3:0]        r_pal_index;
  logic              r_pal_hit;
  logic              r_pal_valid;

  // Valid bits advance every cycle; data registers only load on a valid slot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rom_addr  <= '0;
      r_in1       <= 1'b0;
      r_v1        <= 1'b0;
      r_in2       <= 1'b0;
      r_v2        <= 1'b0;
      r_pal_index <= COLOR_KEY_IDX;
      r_pal_hit   <= 1'b0;
      r_pal_valid <= 1'b0;
    end else begin
      r_v1 <= i_pix_en;
      if (i_pix_en) begin
        r_in1      <= w_in;
        r_rom_addr <= w_in ? w_addr : '0;
      end

      r_v2 <= r_v1;
      if (r_v1) begin
        r_in2 <= r_in1;
      end

      r_pal_valid <= r_v2;
      if (r_v2) begin
        r_pal_index <= r_in2 ? i_rom_data : COLOR_KEY_IDX;
        r_pal_hit   <= r_in2 && (i_rom_data != COLOR_KEY_IDX);
      end
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_pal_index = r_pal_index;
  assign o_pal_hit   = r_pal_hit;
  assign o_pal_valid = r_pal_valid;

endmodule

// File: tb/tb_girl_sprite_fetch.sv
// Bench for girl_sprite_fetch: directed literal cases plus randomized traffic vs a pixel model.
module tb_girl_sprite_fetch;
  import sprite_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start, moving, face_left, pix_en;
  pix_coord_t        sprite_x, sprite_y, draw_x, draw_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        pal_index;
  logic              pal_hit, pal_valid;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [3:0] mem [0:4095];

  always #5 clk = ~clk;

  girl_sprite_fetch dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_frame_start (frame_start),
    .i_moving      (moving),
    .i_face_left   (face_left),
    .i_sprite_x    (sprite_x),
    .i_sprite_y    (sprite_y),
    .i_draw_x      (draw_x),
    .i_draw_y      (draw_y),
    .i_pix_en      (pix_en),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_pal_index   (pal_index),
    .o_pal_hit     (pal_hit),
    .o_pal_valid   (pal_valid)
  );

  initial rom_data = 4'd0;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-pixel result computed directly, then delayed 3 slots.
  int m_frame, m_hold, m_addr;
  bit m_face;
  bit mv [3];
  int mi [3];
  bit mh [3];

  always @(posedge clk or negedge rst_n) begin : model
    int dx, dy, col;
    bit inb;
    if (!rst_n) begin
      m_frame = 0; m_hold = 0; m_face = 0; m_addr = 0;
      for (int i = 0; i < 3; i++) begin mv[i] = 0; mi[i] = 0; mh[i] = 0; end
    end else begin
      for (int i = 2; i > 0; i--) begin mv[i] = mv[i-1]; mi[i] = mi[i-1]; mh[i] = mh[i-1]; end
      mv[0] = pix_en;
      if (pix_en) begin
        dx  = int'(draw_x) - int'(sprite_x);
        dy  = int'(draw_y) - int'(sprite_y);
        inb = dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        col = m_face ? 31 - dx : dx;
        m_addr = inb ? m_frame * 1024 + dy * 32 + col : 0;
        mi[0]  = inb ? int'(mem[m_addr]) : 0;
        mh[0]  = inb && mi[0] != 0;
      end
      if (frame_start) begin
        m_face = face_left;
        if (!moving) begin
          m_frame = 0; m_hold = 0;
        end else if (m_hold == 5) begin
          m_hold = 0; m_frame = (m_frame + 1) % 4;
        end else begin
          m_hold++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("rom_addr", int'(rom_addr), m_addr);
      check("pal_valid", int'(pal_valid), int'(mv[2]));
      if (mv[2]) begin
        check("pal_index", int'(pal_index), mi[2]);
        check("pal_hit", int'(pal_hit), int'(mh[2]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
  endtask

  task automatic pixel(input int x, input int y, input int ea, input int ei, input int eh);
    draw_x = 10'(x); draw_y = 10'(y); pix_en = 1'b1;
    tick();
    pix_en = 1'b0; frame_start = 1'b0;
    check("d_rom_addr", int'(rom_addr), ea);
    tick(); tick();
    check("d_pal_valid", int'(pal_valid), 1);
    check("d_pal_index", int'(pal_index), ei);
    check("d_pal_hit", int'(pal_hit), eh);
  endtask

  task automatic check_reset_outputs();
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_pal_index", int'(pal_index), 0);
    check("rst_pal_hit", int'(pal_hit), 0);
    check("rst_pal_valid", int'(pal_valid), 0);
  endtask

  initial begin
    logic [5:0] pat;
    rst_n = 1'b0; frame_start = 0; moving = 0; face_left = 0; pix_en = 0;
    sprite_x = 10'd100; sprite_y = 10'd50; draw_x = 0; draw_y = 0;
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    mem[69] = 4'd3; mem[90] = 4'd9; mem[70] = 4'd0; mem[1093] = 4'd5;
    #1;
    check_reset_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Basic hit, mirrored hit, right-edge miss
    pixel(105, 52, 69, 3, 1);
    face_left = 1'b1; pulse();
    pixel(105, 52, 90, 9, 1);
    pixel(132, 52, 0, 0, 0);

    // Animation stepping
    face_left = 1'b0; moving = 1'b1;
    repeat (6) pulse();
    pixel(105, 52, 1093, 5, 1);
    repeat (18) pulse();
    pixel(105, 52, 69, 3, 1);
    repeat (6) pulse();
    moving = 1'b0; pulse();
    pixel(105, 52, 69, 3, 1);

    // Colour key inside the box, then a one-cycle gap in a stream
    pixel(106, 52, 70, 0, 0);
    pat = 6'b110111;
    for (int k = 0; k < 9; k++) begin
      pix_en = (k < 6) ? pat[k] : 1'b0;
      draw_x = 10'(100 + k); draw_y = 10'd52;
      tick();
      if (k >= 2) check("gap_valid", int'(pal_valid), (k - 2 < 6) ? int'(pat[k-2]) : 0);
    end
    pix_en = 1'b0;

    // Off-screen sprite must not alias through 10-bit wrap
    sprite_x = 10'd630; pixel(5, 52, 0, 0, 0);
    sprite_x = 10'd1010; pixel(5, 52, 0, 0, 0);
    sprite_x = 10'd100;

    // Mid-frame face change is ignored until frame_start; coincident pulse uses old face
    face_left = 1'b1; pixel(105, 52, 69, 3, 1);
    pulse();
    face_left = 1'b0; frame_start = 1'b1;
    pixel(105, 52, 90, 9, 1);
    pixel(105, 52, 69, 3, 1);

    // Randomized traffic, with one mid-stream reset
    moving = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) begin
        pix_en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        tick();
        rst_n = 1'b1;
        pix_en = 1'b0;
        tick();
        pix_en = 1'b1; draw_x = sprite_x; draw_y = sprite_y;
        tick(); pix_en = 1'b0;
        check("post_rst_v1", int'(pal_valid), 0);
        tick();
        check("post_rst_v2", int'(pal_valid), 0);
        tick();
        check("post_rst_v3", int'(pal_valid), 1);
      end
      if ($urandom_range(0, 63) == 0) begin
        sprite_x = 10'($urandom_range(0, 1023));
        sprite_y = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 99) == 0) moving = ~moving;
      face_left   = 1'($urandom_range(0, 1));
      frame_start = ($urandom_range(0, 39) == 0);
      pix_en      = ($urandom_range(0, 9) < 8);
      draw_x = 10'(int'(sprite_x) + int'($urandom_range(0, 40)) - 4);
      draw_y = 10'(int'(sprite_y) + int'($urandom_range(0, 40)) - 4);
      tick();
    end
    pix_en = 1'b0; frame_start = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
